// File: rtl/fetch_controller_if.sv
// Decode-side instruction handshake between the fetch controller (master) and decode (slave).
interface fetch_controller_if #(
    parameter int XLEN = 64
);
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instruction;
    logic [XLEN-1:0] out_pc;

    modport master (output out_valid, out_instruction, out_pc, input out_ready);
    modport slave  (input out_valid, out_instruction, out_pc, output out_ready);
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the PC into a combinational-read instruction memory,
// buffers returned words in a small FIFO and hands them to decode over valid/ready.
module fetch_controller #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IMEM_WORDS = 128,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic [XLEN-1:0]     imem_pc,
    input  logic [31:0]         imem_instruction,
    fetch_controller_if.master  dec,
    output logic                busy,
    output logic                halted,
    output logic                fault
);

    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-3:0]  WORD_LIMIT = (XLEN-2)'(IMEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state;
    logic [XLEN-1:0]  pc;

    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             empty;
    logic             full;
    logic             out_of_range;
    logic             fire;
    logic             end_marker;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] head_idx;

    // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        empty        = (count == '0);
        full         = (count == CNT_FULL);
        // Full-width index compare so a PC past the memory never aliases back onto word 0.
        out_of_range = (state == S_FETCH) && !redirect_valid && (pc[XLEN-1:2] >= WORD_LIMIT);
        fire         = (state == S_FETCH) && !redirect_valid && !full && !out_of_range;
        end_marker   = fire && (imem_instruction == 32'h0000_0000);
        push         = fire && !end_marker;
        pop          = !empty && dec.out_ready && !redirect_valid;
        // An empty buffer keeps presenting the entry that was last at the head.
        head_idx     = empty ? (rd_ptr - PTR_ONE) : rd_ptr;
    end

    // NOTE: the buffer storage is reset because its head drives the outputs even when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            // Step past the live head so the empty buffer still shows it.
            if (!empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                wr_ptr <= rd_ptr + PTR_ONE;
            end
            count <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_instruction;
                fifo_pc[wr_ptr]    <= pc;
                wr_ptr             <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            busy   <= 1'b0;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[XLEN-1:2], 2'b00};
            state  <= S_FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault <= 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (out_of_range) begin
                        fault <= 1'b1;
                        state <= S_DRAIN;
                    end else if (end_marker) begin
                        state <= S_DRAIN;
                    end else if (push) begin
                        pc <= pc + XLEN'(4);
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state  <= S_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        state  <= S_FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign imem_pc             = pc;
    assign dec.out_valid       = !empty;
    assign dec.out_instruction = fifo_instr[head_idx];
    assign dec.out_pc          = fifo_pc[head_idx];

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a program-order stream model predicts every delivered
// (instruction, pc) pair; a negedge monitor pops and compares each accepted handshake.
module tb_fetch_controller;

    localparam int XLEN  = 64;
    localparam int WORDS = 128;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        start          = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = '0;
    logic [63:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        busy;
    logic        halted;
    logic        fault;

    logic [31:0] mem [WORDS];
    logic        rand_ready = 1'b0;
    logic        ready_set  = 1'b0;
    logic        rnd_ready  = 1'b0;

    item_t       exp_q[$];
    item_t       mon_e;
    logic [63:0] exp_end_pc = '0;
    logic        exp_fault  = 1'b0;
    logic        exp_oor    = 1'b0;
    int          n_checks   = 0;
    int          n_fail     = 0;

    fetch_controller_if #(.XLEN(XLEN)) dec ();

    assign dec.out_ready     = rand_ready ? rnd_ready : ready_set;
    assign imem_instruction  = mem[imem_pc[8:2]];

    fetch_controller #(
        .XLEN       (XLEN),
        .RESET_PC   (64'h0),
        .IMEM_WORDS (WORDS),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .dec              (dec),
        .busy             (busy),
        .halted           (halted),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head (outside a redirect cycle) must be the next predicted pair.
    always @(negedge clk) begin
        if (rst_n && dec.out_valid && dec.out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc 0x%0h instr 0x%0h, expected no delivery",
                         dec.out_pc, dec.out_instruction);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_instr", 64'(dec.out_instruction), 64'(mon_e.instr));
                check("pop_pc", dec.out_pc, mon_e.pc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Program-order model: words from p0 up to the zero marker or the end of memory.
    task automatic build_stream(input logic [63:0] p0);
        logic [63:0] p;
        p       = p0;
        exp_oor = 1'b0;
        for (int k = 0; k <= WORDS; k++) begin
            if ((p >> 2) >= 64'(WORDS)) begin
                exp_oor   = 1'b1;
                exp_fault = 1'b1;
                break;
            end
            if (mem[p[8:2]] == 32'h0) break;
            exp_q.push_back('{instr: mem[p[8:2]], pc: p});
            p = p + 64'd4;
        end
        exp_end_pc = p;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_fault  = 1'b0;
        exp_end_pc = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        build_stream(exp_end_pc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_redirect(input logic [63:0] target);
        exp_q.delete();
        if (target[1:0] != 2'b00) exp_fault = 1'b1;
        build_stream({target[63:2], 2'b00});
        redirect_pc    = target;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(halted), 64'd1);
        tick();
    endtask

    task automatic check_end(input string tag);
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pc"}, imem_pc, exp_end_pc);
        check({tag, "_fault"}, 64'(fault), 64'(exp_fault));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0000;
    endtask

    task automatic load_random();
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
        end
    endtask

    initial begin
        logic [63:0] target;

        // Straight-line program, then resume from HALTED at the stored pc.
        load_basic();
        do_reset();
        ready_set = 1'b1;
        check("rst_out_valid", 64'(dec.out_valid), 64'd0);
        check("rst_out_instruction", 64'(dec.out_instruction), 64'd0);
        check("rst_out_pc", dec.out_pc, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_imem_pc", imem_pc, 64'd0);
        tick();
        pulse_start();
        @(negedge clk);
        check("t1_first_cycle_empty", 64'(dec.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_consecutive_valid", 64'(dec.out_valid), 64'd1);
            check("t1_consecutive_pc", dec.out_pc, 64'(4 * i));
        end
        tick();
        wait_halted("t1_halted", 200);
        check_end("t1");
        mem[3] = 32'h0030_0193;
        mem[4] = 32'h0;
        pulse_start();
        wait_halted("t1_resume_halted", 200);
        check_end("t1_resume");

        // Back-pressure: two entries buffered, pc held at 8.
        load_basic();
        do_reset();
        ready_set = 1'b0;
        tick();
        pulse_start();
        tick(5);
        check("t2_pc_held", imem_pc, 64'h8);
        check("t2_valid", 64'(dec.out_valid), 64'd1);
        check("t2_head_pc", dec.out_pc, 64'h0);
        check("t2_busy", 64'(busy), 64'd1);
        ready_set = 1'b1;
        wait_halted("t2_halted", 200);
        check_end("t2");

        // Redirect with a full buffer while decode is accepting.
        for (int i = 0; i < WORDS; i++) mem[i] = (i < 24) ? ($urandom | 32'h1) : 32'h0;
        do_reset();
        ready_set = 1'b0;
        tick();
        pulse_start();
        tick(3);
        check("t3_buffered_pc", imem_pc, 64'h8);
        ready_set = 1'b1;
        do_redirect(64'h40);
        @(negedge clk);
        check("t3_flush_valid", 64'(dec.out_valid), 64'd0);
        @(negedge clk);
        check("t3_first_valid", 64'(dec.out_valid), 64'd1);
        check("t3_first_pc", dec.out_pc, 64'h40);
        check("t3_first_instr", 64'(dec.out_instruction), 64'(mem[16]));
        tick();
        wait_halted("t3_halted", 300);
        check_end("t3");

        // Misaligned redirect issued from HALTED.
        do_redirect(64'h42);
        check("t4_fault", 64'(fault), 64'd1);
        check("t4_pc_aligned", imem_pc, 64'h40);
        check("t4_not_halted", 64'(halted), 64'd0);
        check("t4_busy", 64'(busy), 64'd1);
        wait_halted("t4_halted", 300);
        check_end("t4");

        // Run off the end of memory with random back-pressure.
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0000_0013;
        do_reset();
        rand_ready = 1'b1;
        tick();
        pulse_start();
        wait_halted("t5_halted", 3000);
        check_end("t5");

        // Random programs, random redirect targets, random stray start pulses.
        load_random();
        do_reset();
        rand_ready = 1'b1;
        tick();
        for (int it = 0; it < 14; it++) begin
            if (it == 6) begin
                target = 64'hFFFF_FFFF_FFFF_FFFC;
            end else begin
                target = (64'($urandom_range(0, WORDS - 1)) << 2) |
                         (($urandom_range(0, 3) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
            end
            do_redirect(target);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 8)) begin
                    start = ($urandom_range(0, 5) == 0);
                    tick();
                end
                start = 1'b0;
            end else begin
                wait_halted("rand_halted", 3000);
                check_end("rand");
            end
        end

        // Asynchronous reset with one entry buffered.
        load_basic();
        do_reset();
        rand_ready = 1'b0;
        ready_set  = 1'b0;
        tick();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("t6_one_buffered", 64'(dec.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_fault  = 1'b0;
        exp_end_pc = 64'h0;
        #1;
        check("t6_async_valid_drop", 64'(dec.out_valid), 64'd0);
        check("t6_async_pc", imem_pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("t6_idle_pc", imem_pc, 64'h0);
        check("t6_idle_valid", 64'(dec.out_valid), 64'd0);
        check("t6_idle_busy", 64'(busy), 64'd0);
        check("t6_idle_halted", 64'(halted), 64'd0);
        check("t6_idle_fault", 64'(fault), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 128-word, combinational-read instruction memory for the sequential core.
- Owns the fetch PC and drives it to the memory's `pc` input, then captures the returned word.
- Buffers fetched instructions in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles start, redirect (branch/jump), end-of-program and out-of-range halts.

Parameters:
- XLEN, 64, width of the PC and of all address ports.
- RESET_PC, 64'h0, PC loaded on reset.
- IMEM_WORDS, 128, number of instruction words; word index = pc[8:2].
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
- redirect_valid  in  1  flush the buffer and load a new PC.
- redirect_pc  in  XLEN  target PC for a redirect.
- imem_pc  out  XLEN  PC to the instruction memory (registered PC value).
- imem_instruction  in  32  word returned combinationally for imem_pc.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instruction  out  32  head instruction.
- out_pc  out  XLEN  PC of the head instruction.
- busy  out  1  state is FETCH or DRAIN.
- halted  out  1  state is HALTED.
- fault  out  1  sticky; set on a misaligned redirect or an out-of-range fetch.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC, FIFO empty.
  - out_valid=0, out_instruction=0, out_pc=0, busy=0, halted=0, fault=0.
- imem_pc = pc at all times; the memory read is combinational, so capture happens in the same cycle (0-cycle latency).
- A fetch "fires" when state=FETCH, the FIFO is not full, and redirect_valid=0.
- On fire:
  - The pair {imem_instruction, pc} is pushed and pc <= pc+4.
  - Exception: if imem_instruction == 32'h00000000 (end-of-program marker), nothing is pushed, pc holds, and state -> DRAIN.
- Out-of-range:
  - If pc[XLEN-1:2] >= IMEM_WORDS while in FETCH, nothing is pushed, fault<=1, state -> DRAIN.
  - The check uses the full index, not the truncated pc[8:2], so there is no wrap-around.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Full FIFO: no fetch; pc holds. The empty FIFO gives out_valid=0.
- Outputs out_instruction and out_pc come straight from the FIFO head (no extra register stage). When empty, they hold the last head value.
- States:
  - IDLE: start -> FETCH. Other inputs are ignored except redirect.
  - FETCH: fetches as above.
  - DRAIN: no fetching. When the FIFO is empty (after pops) -> HALTED.
  - HALTED: halted=1. start -> FETCH, resuming at the current pc.
- Redirect (redirect_valid=1, any state) takes priority over everything else that cycle:
  - The FIFO is flushed and any pop that cycle is discarded.
  - pc <= redirect_pc and state -> FETCH. The first fetch at the new PC happens next cycle.
  - If redirect_pc[1:0] != 0, fault<=1, pc <= redirect_pc with the low 2 bits forced to 0, state -> FETCH.
- start while in FETCH or DRAIN has no effect.
- fault clears only on reset.
- pc+4 is modulo 2^XLEN.

Test Plan:
1. Reset memory with words 0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x00000000; out_ready=1; pulse start -> out_valid with (instruction, pc) pairs (0x00500093, 0), (0x00100113, 4), (0x002081B3, 8) on consecutive cycles; then DRAIN, then halted=1, pc=12.
2. Back-pressure: out_ready=0 for 5 cycles after start -> exactly 2 entries buffered; pc=8 holds. Raise out_ready -> pcs 0, 4, 8 delivered in order, nothing dropped or duplicated.
3. Redirect with 2 entries buffered and out_ready=1, redirect_pc=0x40 -> the next cycle has out_valid=0. The following cycle delivers the head with out_pc=0x40 and the word stored at index 16.
4. Redirect to 0x42 -> fault=1 and fetch resumes at 0x40. Redirect in HALTED -> state FETCH, halted=0.
5. Memory filled with NOPs (0x00000013), run to pc=0x200 -> fault=1, no push at index 128, DRAIN, then HALTED after the FIFO empties.
6. Assert rst_n low mid-fetch with 1 entry buffered -> out_valid drops to 0 immediately (asynchronously); after release pc=RESET_PC and state is IDLE.
